// File: rtl/uart_pkg.sv
// Shared FSM types for the UART loopback BIST controller.
package uart_pkg;
  localparam int BIST_STATE_W = 3;

  typedef enum logic [BIST_STATE_W-1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RX,
    ST_DONE
  } bist_state_t;
endpackage

// File: rtl/bist_timeout_timer.sv
// Echo timeout down-counter: tc fires TIMEOUT-1 cycles after the load cycle
// while enabled.
module bist_timeout_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The load cycle itself is the first elapsed cycle, so terminal count is 0
  // after TIMEOUT-2 decrements.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)             cnt <= '0;
    else if (load)                cnt <= LOAD_VAL;
    else if (en && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign tc = en && (cnt == '0);
endmodule

// File: rtl/uart_loopback_bist.sv
// Stop-and-wait UART loopback checker: ROM word -> tx, compare echo, count errors.
// Optional fault injection on bit 0 when UART_BIST_INJECT_EN is defined.
module uart_loopback_bist
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 1024,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
`ifdef UART_BIST_INJECT_EN
  input  logic                  inject,
  input  logic [ADDR_WIDTH-1:0] inject_addr,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err,
  output logic [ADDR_WIDTH:0]   words_sent
);
  bist_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, last_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  pass_q, to_tc, last_word, err_hit, flip;

  assign rom_addr  = idx;
  assign last_word = (idx == last_q) || (idx == {ADDR_WIDTH{1'b1}});

`ifdef UART_BIST_INJECT_EN
  assign flip = inject && (idx == inject_addr);
`else
  assign flip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    pass      = pass_q;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (rom_data == '0) ? ST_DONE : ST_SEND;
      ST_SEND: begin
        tx_start = tx_ready;
        if (tx_ready) state_nxt = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        // An echo landing on the terminal-count cycle takes priority.
        if (rx_valid)   state_nxt = last_word ? ST_DONE : ST_FETCH;
        else if (to_tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        pass      = (err_count == '0) && !timeout;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Any echo outside WAIT_RX during a run is spurious and counts as an error.
  assign err_hit = (busy && rx_valid && (state != ST_WAIT_RX || rx_data != exp_q))
                || (state == ST_WAIT_RX && to_tc && !rx_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      last_q     <= '0;
      tx_data    <= '0;
      exp_q      <= '0;
      pass_q     <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      first_err  <= '0;
      words_sent <= '0;
    end else if (state == ST_IDLE && start) begin
      idx        <= '0;
      last_q     <= last_addr;
      pass_q     <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      first_err  <= '0;
      words_sent <= '0;
    end else begin
      if (state == ST_LOAD) begin
        exp_q   <= rom_data;
        tx_data <= rom_data ^ DATA_WIDTH'(flip);
      end
      if (state == ST_SEND && tx_ready)                 words_sent <= words_sent + 1'b1;
      if (state == ST_WAIT_RX && rx_valid && !last_word) idx       <= idx + 1'b1;
      if (state == ST_WAIT_RX && to_tc && !rx_valid)     timeout   <= 1'b1;
      if (state == ST_DONE)                              pass_q    <= pass;
      if (err_hit) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err <= idx;
      end
    end
  end

  bist_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .load (state == ST_SEND && tx_ready),
    .en   (state == ST_WAIT_RX),
    .tc   (to_tc)
  );
endmodule
